// File: rtl/avg_pkg.sv
// avg_pkg: shared constants, FSM state type and leaky-integrator step function for avg_multi
package avg_pkg;
  localparam int DK_W = 5;
  localparam int STEP_W = 32;
  typedef enum logic {CLEAR, RUN} state_e;
  function automatic logic [STEP_W-1:0] step_f(input logic [STEP_W-1:0] acc, input logic [STEP_W-1:0] data, input logic [DK_W-1:0] k);
    return $signed(acc) - ($signed(acc) >>> k) + ($signed(data) >>> k);
  endfunction
endpackage

// File: rtl/avg_step.sv
// avg_step: combinational leaky-integrator step new_o = acc_i - (acc_i>>>k_i) + (data_i>>>k_i), signed arithmetic
module avg_step import avg_pkg::*; #(
  parameter int ACC_W = 32
) (
  input  logic [ACC_W-1:0] acc_i,
  input  logic [ACC_W-1:0] data_i,
  input  logic [DK_W-1:0]  k_i,
  output logic [ACC_W-1:0] new_o
);
  assign new_o = $signed(acc_i) - ($signed(acc_i) >>> k_i) + ($signed(data_i) >>> k_i);
endmodule

// File: rtl/avg_multi.sv
// avg_multi: time-multiplexed NCH-channel leaky-integrator average (valid/ready in, 2-cycle latency out, CLEAR sweep on reset/clr_req, optional per-channel peak hold with AVG_PEAK_EN)
module avg_multi import avg_pkg::*; #(
  parameter int NCH     = 4,
  parameter int CH_W    = $clog2(NCH),
  parameter int ACC_W   = 32,
  parameter int OUT_W   = 10,
  parameter int OUT_MSB = 30
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr_req,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [CH_W-1:0]  in_ch,
  input  logic [ACC_W-1:0] in_data,
  input  logic [DK_W-1:0]  dk_const,
  output logic             out_valid,
  output logic [CH_W-1:0]  out_ch,
  output logic [OUT_W-1:0] out_data,
  output logic [OUT_W-1:0] peak_data
);
  state_e           state_q;
  logic [CH_W-1:0]  idx_q;
  logic             in_ready_q;
  logic             s1_v_q;
  logic [CH_W-1:0]  s1_ch_q;
  logic [ACC_W-1:0] s1_data_q;
  logic [ACC_W-1:0] s1_acc_q;
  logic [DK_W-1:0]  s1_k_q;
  logic             out_valid_q;
  logic [CH_W-1:0]  out_ch_q;
  logic [OUT_W-1:0] out_data_q;
  logic [ACC_W-1:0] acc_mem [NCH];
  logic [ACC_W-1:0] new_acc;
  logic [OUT_W-1:0] new_slice;
  logic             accept;
  logic             clearing;
  logic             we;
  logic [CH_W-1:0]  wa;
  logic [ACC_W-1:0] wd;
  assign accept    = in_valid & in_ready_q;
  assign clearing  = state_q == CLEAR;
  assign we        = clearing | s1_v_q;
  assign wa        = clearing ? idx_q : s1_ch_q;
  assign wd        = clearing ? '0 : new_acc;
  assign new_slice = new_acc[OUT_MSB -: OUT_W];
  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign out_ch    = out_ch_q;
  assign out_data  = out_data_q;
  avg_step #(.ACC_W(ACC_W)) u_step (
    .acc_i  (s1_acc_q),
    .data_i (s1_data_q),
    .k_i    (s1_k_q),
    .new_o  (new_acc)
  );
  always_ff @(posedge clk) begin
    if (we) acc_mem[wa] <= wd;
    if (accept) begin
      s1_ch_q   <= in_ch;
      s1_data_q <= in_data;
      s1_k_q    <= dk_const;
      s1_acc_q  <= (we && wa == in_ch) ? wd : acc_mem[in_ch];
    end
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= CLEAR;
      idx_q       <= '0;
      in_ready_q  <= 1'b0;
      s1_v_q      <= 1'b0;
      out_valid_q <= 1'b0;
      out_ch_q    <= '0;
      out_data_q  <= '0;
    end else begin
      s1_v_q      <= accept;
      out_valid_q <= s1_v_q;
      if (s1_v_q) begin
        out_ch_q   <= s1_ch_q;
        out_data_q <= new_slice;
      end
      if (clearing) begin
        if (clr_req) idx_q <= '0;
        else if (idx_q == CH_W'(NCH - 1)) begin
          state_q    <= RUN;
          in_ready_q <= 1'b1;
        end else idx_q <= idx_q + 1'b1;
      end else if (clr_req) begin
        state_q    <= CLEAR;
        idx_q      <= '0;
        in_ready_q <= 1'b0;
      end
    end
  end
`ifdef AVG_PEAK_EN
  logic [OUT_W-1:0] pk_mem [NCH];
  logic [OUT_W-1:0] pk_rd_q;
  logic [OUT_W-1:0] pk_new;
  logic [OUT_W-1:0] pk_wd;
  logic [OUT_W-1:0] peak_q;
  assign pk_new    = $signed(new_slice) > $signed(pk_rd_q) ? new_slice : pk_rd_q;
  assign pk_wd     = clearing ? '0 : pk_new;
  assign peak_data = peak_q;
  always_ff @(posedge clk) begin
    if (we) pk_mem[wa] <= pk_wd;
    if (accept) pk_rd_q <= (we && wa == in_ch) ? pk_wd : pk_mem[in_ch];
  end
  always_ff @(posedge clk) begin
    if (!rst_n) peak_q <= '0;
    else if (s1_v_q) peak_q <= pk_new;
  end
`else
  assign peak_data = '0;
`endif
endmodule

// File: tb/tb_avg_multi.sv
// tb_avg_multi: directed self-checking bench for avg_multi with hand-computed expected averages
module tb_avg_multi;
  localparam int NCH = 4;
  localparam int CH_W = 2;
  localparam int ACC_W = 32;
  localparam int OUT_W = 10;
  localparam logic [ACC_W-1:0] BIG = 32'h4000_0000;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic clr_req = 1'b0;
  logic in_valid = 1'b0;
  logic in_ready;
  logic [CH_W-1:0] in_ch = '0;
  logic [ACC_W-1:0] in_data = '0;
  logic [4:0] dk_const = '0;
  logic out_valid;
  logic [CH_W-1:0] out_ch;
  logic [OUT_W-1:0] out_data;
  logic [OUT_W-1:0] peak_data;
  int errors = 0;
  int checks = 0;
  logic [CH_W-1:0] s_ch [16];
  logic [ACC_W-1:0] s_data [16];
  logic [4:0] s_k [16];
  logic g_v [16];
  logic [CH_W-1:0] g_ch [16];
  logic [OUT_W-1:0] g_data [16];
  logic [OUT_W-1:0] g_pk [16];
  avg_multi dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .clr_req   (clr_req),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_ch     (in_ch),
    .in_data   (in_data),
    .dk_const  (dk_const),
    .out_valid (out_valid),
    .out_ch    (out_ch),
    .out_data  (out_data),
    .peak_data (peak_data)
  );
  always #5 clk = ~clk;
  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic run_stream(input int n);
    for (int c = 0; c <= n; c++) begin
      in_valid = c < n;
      if (c < n) begin
        in_ch = s_ch[c];
        in_data = s_data[c];
        dk_const = s_k[c];
      end
      tick();
      if (c >= 1) begin
        g_v[c-1] = out_valid;
        g_ch[c-1] = out_ch;
        g_data[c-1] = out_data;
        g_pk[c-1] = peak_data;
      end
    end
    in_valid = 1'b0;
  endtask
  task automatic wait_ready;
    for (int i = 0; i < 20 && !in_ready; i++) tick();
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL wait_ready: in_ready=%b required 1 within 20 cycles", in_ready);
    end
  endtask
  task automatic do_clear;
    clr_req = 1'b1;
    tick();
    clr_req = 1'b0;
    wait_ready();
  endtask
  task automatic test_reset;
    rst_n = 1'b0;
    tick();
    tick();
    checks++;
    if ({in_ready, out_valid, out_ch, out_data, peak_data} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: ready=%b valid=%b ch=%0d data=%0d peak=%0d required all 0", in_ready, out_valid, out_ch, out_data, peak_data);
    end
    rst_n = 1'b1;
    checks++;
    if (in_ready !== 1'b0) begin
      errors++;
      $display("FAIL reset_ready[0]: in_ready=%b required 0", in_ready);
    end
    for (int k = 1; k <= NCH; k++) begin
      tick();
      checks++;
      if (in_ready !== (k == NCH)) begin
        errors++;
        $display("FAIL reset_ready[%0d]: in_ready=%b required %b", k, in_ready, k == NCH);
      end
      checks++;
      if ({out_valid, out_ch, out_data, peak_data} !== '0) begin
        errors++;
        $display("FAIL reset_idle[%0d]: valid=%b ch=%0d data=%0d peak=%0d required all 0", k, out_valid, out_ch, out_data, peak_data);
      end
    end
  endtask
  task automatic test_single;
    int e [6] = '{256, 384, 448, 480, 496, 504};
    for (int j = 0; j < 6; j++) begin
      s_ch[j] = 0;
      s_data[j] = BIG;
      s_k[j] = 5'd1;
    end
    run_stream(6);
    for (int j = 0; j < 6; j++) begin
      checks++;
      if (g_v[j] !== 1'b1 || g_ch[j] !== 2'd0 || g_data[j] !== OUT_W'(e[j])) begin
        errors++;
        $display("FAIL single[%0d]: valid=%b ch=%0d data=%0d required 1/0/%0d", j, g_v[j], g_ch[j], g_data[j], e[j]);
      end
    end
  endtask
  task automatic test_interleave;
    int e [4] = '{256, 384, 448, 480};
    do_clear();
    for (int j = 0; j < 8; j++) begin
      s_ch[j] = CH_W'(j % 2);
      s_data[j] = (j % 2 == 0) ? BIG : '0;
      s_k[j] = 5'd1;
    end
    run_stream(8);
    for (int j = 0; j < 8; j++) begin
      checks++;
      if (g_v[j] !== 1'b1 || g_ch[j] !== CH_W'(j % 2) || g_data[j] !== ((j % 2 == 0) ? OUT_W'(e[j/2]) : '0)) begin
        errors++;
        $display("FAIL interleave[%0d]: valid=%b ch=%0d data=%0d required 1/%0d/%0d", j, g_v[j], g_ch[j], g_data[j], j % 2, (j % 2 == 0) ? e[j/2] : 0);
      end
    end
  endtask
  task automatic test_back_to_back;
    int e [5] = '{128, 224, 296, 350, 390};
    do_clear();
    for (int j = 0; j < 5; j++) begin
      s_ch[j] = 2'd3;
      s_data[j] = BIG;
      s_k[j] = 5'd2;
    end
    run_stream(5);
    for (int j = 0; j < 5; j++) begin
      checks++;
      if (g_v[j] !== 1'b1 || g_ch[j] !== 2'd3 || g_data[j] !== OUT_W'(e[j])) begin
        errors++;
        $display("FAIL back_to_back[%0d]: valid=%b ch=%0d data=%0d required 1/3/%0d", j, g_v[j], g_ch[j], g_data[j], e[j]);
      end
    end
  endtask
  task automatic test_clear;
    int n = 0;
    do_clear();
    for (int j = 0; j < 4; j++) begin
      s_ch[j] = 0;
      s_data[j] = BIG;
      s_k[j] = 5'd1;
    end
    run_stream(4);
    checks++;
    if (g_data[3] !== 10'd480) begin
      errors++;
      $display("FAIL clear_pre: data=%0d required 480", g_data[3]);
    end
    clr_req = 1'b1;
    tick();
    clr_req = 1'b0;
    while (!in_ready && n < 20) begin
      n++;
      tick();
    end
    checks++;
    if (n != NCH) begin
      errors++;
      $display("FAIL clear_ready_low: low_cycles=%0d required %0d", n, NCH);
    end
    run_stream(1);
    checks++;
    if (g_v[0] !== 1'b1 || g_data[0] !== 10'd256) begin
      errors++;
      $display("FAIL clear_post: valid=%b data=%0d required 1/256", g_v[0], g_data[0]);
    end
  endtask
  task automatic test_clr_accept;
    in_valid = 1'b1;
    in_ch = 2'd1;
    in_data = 32'h1234_5678;
    dk_const = 5'd0;
    clr_req = 1'b1;
    tick();
    in_valid = 1'b0;
    clr_req = 1'b0;
    checks++;
    if (in_ready !== 1'b0) begin
      errors++;
      $display("FAIL clr_accept_ready: in_ready=%b required 0", in_ready);
    end
    tick();
    checks++;
    if (out_valid !== 1'b1 || out_ch !== 2'd1 || out_data !== 10'd145) begin
      errors++;
      $display("FAIL clr_accept_out: valid=%b ch=%0d data=%0d required 1/1/145", out_valid, out_ch, out_data);
    end
    wait_ready();
    s_ch[0] = 2'd1;
    s_data[0] = BIG;
    s_k[0] = 5'd1;
    run_stream(1);
    checks++;
    if (g_v[0] !== 1'b1 || g_data[0] !== 10'd256) begin
      errors++;
      $display("FAIL clr_accept_post: valid=%b data=%0d required 1/256", g_v[0], g_data[0]);
    end
  endtask
  task automatic test_reset_mid;
    in_valid = 1'b1;
    in_ch = 2'd2;
    in_data = BIG;
    dk_const = 5'd0;
    tick();
    in_valid = 1'b0;
    rst_n = 1'b0;
    tick();
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid[0]: valid=%b ready=%b required 0/0", out_valid, in_ready);
    end
    rst_n = 1'b1;
    tick();
    checks++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid[1]: valid=%b required 0", out_valid);
    end
    wait_ready();
  endtask
  task automatic test_peak;
    int e [8] = '{256, 384, 448, 480, 240, 120, 60, 30};
`ifdef AVG_PEAK_EN
    int p [8] = '{256, 384, 448, 480, 480, 480, 480, 480};
`else
    int p [8] = '{0, 0, 0, 0, 0, 0, 0, 0};
`endif
    for (int j = 0; j < 8; j++) begin
      s_ch[j] = 2'd2;
      s_data[j] = (j < 4) ? BIG : '0;
      s_k[j] = 5'd1;
    end
    run_stream(8);
    for (int j = 0; j < 8; j++) begin
      checks++;
      if (g_v[j] !== 1'b1 || g_ch[j] !== 2'd2 || g_data[j] !== OUT_W'(e[j]) || g_pk[j] !== OUT_W'(p[j])) begin
        errors++;
        $display("FAIL peak[%0d]: valid=%b ch=%0d data=%0d peak=%0d required 1/2/%0d/%0d", j, g_v[j], g_ch[j], g_data[j], g_pk[j], e[j], p[j]);
      end
    end
  endtask
  initial begin
    test_reset();
    test_single();
    test_interleave();
    test_back_to_back();
    test_clear();
    test_clr_accept();
    test_reset_mid();
    test_peak();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
